sop_lut_gate_seq: RTL

Parametrised, clocked successor to the fixed-function SOP gates. It implements any N-input Boolean function as a programmable minterm mask (truth table). The mask is loaded serially through a valid/ready config port, and a built-in sweep engine enumerates every input combination. It sits beside the fixed SOP gates as a reconfigurable drop-in with registered outputs and self-enumeration for bring-up.

---
 rtl/sop_lut_gate_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sop_lut_gate_seq.sv
// Programmable N-input Boolean function: registered truth-table lookup with a serial
// mask loader and a self-enumerating sweep. Optional macro SOP_LUT_MINTERM_COUNT_EN adds ones_count/is_const.
module sop_lut_gate_seq #(
    parameter int N_IN = 3,
    parameter logic [(2**N_IN)-1:0] DEFAULT_MASK = 8'b0001_0011
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_valid,
    output logic            f,
    output logic            f_valid,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    input  logic            sweep_start,
    output logic            sweep_valid,
    output logic [N_IN-1:0] sweep_idx,
    output logic            sweep_f,
    output logic            sweep_done,
    output logic            busy
`ifdef SOP_LUT_MINTERM_COUNT_EN
    ,
    output logic [N_IN:0]   ones_count,
    output logic            is_const
`endif
);
    localparam int D = 2**N_IN;

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

    state_t          state;
    logic [D-1:0]    mask;
    logic [D-1:0]    shadow;
    logic [D-1:0]    merged;
    logic [N_IN:0]   cnt;
    logic [N_IN-1:0] index;
    logic            accept;
    logic            last_bit;

    // cfg_ready is a registered copy of (state == LOAD), so it doubles as the LOAD qualifier
    assign accept   = cfg_valid & cfg_ready;
    assign last_bit = (cnt == (N_IN+1)'(D-1));

    always_comb begin
        merged = shadow;
        merged[cnt[N_IN-1:0]] = cfg_bit;
    end

`ifdef SOP_LUT_MINTERM_COUNT_EN
    function automatic logic [N_IN:0] popcnt(input logic [D-1:0] v);
        logic [N_IN:0] s;
        s = '0;
        for (int k = 0; k < D; k++) s = s + (N_IN+1)'(v[k]);
        return s;
    endfunction

    logic [N_IN:0] merged_pop;
    assign merged_pop = popcnt(merged);
`endif

    // Eval path runs in every state; f holds while in_valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            f       <= 1'b0;
            f_valid <= 1'b0;
        end else begin
            f_valid <= in_valid;
            if (in_valid) f <= mask[in_vec];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mask        <= DEFAULT_MASK;
            shadow      <= '0;
            cnt         <= '0;
            index       <= '0;
            cfg_ready   <= 1'b0;
            cfg_done    <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_idx   <= '0;
            sweep_f     <= 1'b0;
            sweep_done  <= 1'b0;
            busy        <= 1'b0;
`ifdef SOP_LUT_MINTERM_COUNT_EN
            ones_count  <= popcnt(DEFAULT_MASK);
            is_const    <= (popcnt(DEFAULT_MASK) == '0) ||
                           (popcnt(DEFAULT_MASK) == (N_IN+1)'(D));
`endif
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end else if (sweep_start) begin
                        // Beat 0 is issued on the start edge itself
                        state       <= SWEEP;
                        busy        <= 1'b1;
                        sweep_valid <= 1'b1;
                        sweep_idx   <= '0;
                        sweep_f     <= mask[0];
                        sweep_done  <= 1'b0;
                        index       <= N_IN'(1);
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shadow <= merged;
                        if (last_bit) begin
                            mask      <= merged;
                            cnt       <= '0;
                            cfg_done  <= 1'b1;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
`ifdef SOP_LUT_MINTERM_COUNT_EN
                            ones_count <= merged_pop;
                            is_const   <= (merged_pop == '0) ||
                                          (merged_pop == (N_IN+1)'(D));
`endif
                        end else begin
                            cnt <= cnt + (N_IN+1)'(1);
                        end
                    end
                end
                SWEEP: begin
                    if (sweep_done) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        sweep_valid <= 1'b0;
                        sweep_done  <= 1'b0;
                        sweep_idx   <= '0;
                        sweep_f     <= 1'b0;
                    end else begin
                        sweep_idx  <= index;
                        sweep_f    <= mask[index];
                        sweep_done <= (index == N_IN'(D-1));
                        index      <= index + N_IN'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
